// File: rtl/sensor_frontend_pkg.sv
// Shared types and constants for the sensor front end (contact debounce + serial temperature reader).
package sensor_frontend_pkg;

  localparam int FRAME_BITS = 8;
  localparam int TEMP_W     = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    SHIFT  = 2'd2,
    DONE   = 2'd3
  } fsm_state_e;

  // A frame is good when the total count of ones, parity bit included, is even.
  function automatic logic frame_parity_ok(input logic [FRAME_BITS-1:0] frame);
    return ~(^frame);
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser followed by a stability counter for one contact input.
// fast_en_i lets a synced high set the output at once; release is always debounced.
module sensor_debounce
  import sensor_frontend_pkg::*;
#(
  parameter int DEB_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic fast_en_i,
  input  logic raw_i,
  output logic deb_o
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The fast path looks one flop early so the output rises together with the synced value.
  always_comb begin
    out_d = out_q;
    cnt_d = cnt_q;
    if (fast_en_i && sync1_q && !out_q) begin
      out_d = 1'b1;
      cnt_d = '0;
    end else if (sync2_q != out_q) begin
      if (cnt_q == CNT_LAST) begin
        out_d = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      out_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb_o = out_q;

endmodule

// File: rtl/sensor_frontend.sv
// Sensor front end: debounced contacts and a periodic 3-wire temperature read with parity check.
// Define FA_FAST_EN to let the fire alarm contact assert without waiting for debounce.
module sensor_frontend
  import sensor_frontend_pkg::*;
#(
  parameter int          DEB_CYCLES = 8,
  parameter int          SAMPLE_DIV = 1000,
  parameter int          SCLK_DIV   = 2,
  parameter logic [6:0]  ST_RESET   = 7'd25
) (
  input  logic              clk,
  input  logic              Rst_n,
  input  logic              raw_fd,
  input  logic              raw_rd,
  input  logic              raw_w,
  input  logic              raw_fa,
  input  logic              temp_sdo,
  output logic              temp_cs_n,
  output logic              temp_sclk,
  output logic              SFD,
  output logic              SRD,
  output logic              SW,
  output logic              SFA,
  output logic [TEMP_W-1:0] ST,
  output logic              st_valid,
  output logic              st_err
);

`ifdef FA_FAST_EN
  localparam logic FA_FAST = 1'b1;
`else
  localparam logic FA_FAST = 1'b0;
`endif

  localparam int TMR_W = $clog2(SAMPLE_DIV);
  localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(2 * SCLK_DIV) : 1;
  localparam logic [TMR_W-1:0] TMR_ONE     = TMR_W'(1);
  localparam logic [TMR_W-1:0] TMR_LAST    = TMR_W'(SAMPLE_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE     = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(2 * SCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_RISE_M1 = DIV_W'(SCLK_DIV - 1);

  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_fd (
    .clk(clk), .rst_n(Rst_n), .fast_en_i(1'b0), .raw_i(raw_fd), .deb_o(SFD));
  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_rd (
    .clk(clk), .rst_n(Rst_n), .fast_en_i(1'b0), .raw_i(raw_rd), .deb_o(SRD));
  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_w (
    .clk(clk), .rst_n(Rst_n), .fast_en_i(1'b0), .raw_i(raw_w), .deb_o(SW));
  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_fa (
    .clk(clk), .rst_n(Rst_n), .fast_en_i(FA_FAST), .raw_i(raw_fa), .deb_o(SFA));

  fsm_state_e              state_q, state_d;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [2:0]              bit_q, bit_d;
  logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
  logic                    cs_n_q, cs_n_d;
  logic                    sclk_q, sclk_d;
  logic [TEMP_W-1:0]       st_q, st_d;
  logic                    st_valid_q, st_valid_d;
  logic                    st_err_q, st_err_d;
  logic                    trigger_s;

  assign timer_d   = (timer_q == TMR_LAST) ? '0 : timer_q + TMR_ONE;
  assign trigger_s = (timer_q == TMR_LAST) && (state_q == IDLE);

  // sclk and cs_n are computed one cycle ahead so the pins come straight from flops.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    cs_n_d     = cs_n_q;
    sclk_d     = 1'b0;
    st_d       = st_q;
    st_valid_d = 1'b0;
    st_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (trigger_s) begin
          state_d = SELECT;
          cs_n_d  = 1'b0;
        end else begin
          cs_n_d  = 1'b1;
        end
      end
      SELECT: begin
        state_d = SHIFT;
        cs_n_d  = 1'b0;
        div_d   = '0;
        bit_d   = 3'd0;
      end
      SHIFT: begin
        cs_n_d = 1'b0;
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (bit_q == 3'd7) begin
            state_d = DONE;
            cs_n_d  = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          div_d  = div_q + DIV_ONE;
          sclk_d = (div_q >= DIV_RISE_M1);
          if (div_q == DIV_RISE_M1) begin
            shreg_d = {shreg_q[FRAME_BITS-2:0], temp_sdo};
          end else begin
            shreg_d = shreg_q;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        cs_n_d  = 1'b1;
        if (frame_parity_ok(shreg_q)) begin
          st_d       = shreg_q[FRAME_BITS-1:1];
          st_valid_d = 1'b1;
        end else begin
          st_err_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cs_n_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      div_q      <= '0;
      bit_q      <= 3'd0;
      shreg_q    <= '0;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b0;
      st_q       <= ST_RESET;
      st_valid_q <= 1'b0;
      st_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      cs_n_q     <= cs_n_d;
      sclk_q     <= sclk_d;
      st_q       <= st_d;
      st_valid_q <= st_valid_d;
      st_err_q   <= st_err_d;
    end
  end

  assign temp_cs_n = cs_n_q;
  assign temp_sclk = sclk_q;
  assign ST        = st_q;
  assign st_valid  = st_valid_q;
  assign st_err    = st_err_q;

endmodule

// File: tb/tb_sensor_frontend.sv
// Directed bench for sensor_frontend at default parameters; the sensor model shifts
// tx_bits out MSB first, changing temp_sdo when cs_n falls and after each sclk fall.
module tb_sensor_frontend;

`ifdef FA_FAST_EN
  localparam logic FAST = 1'b1;
`else
  localparam logic FAST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       raw_fd = 1'b0, raw_rd = 1'b0, raw_w = 1'b0, raw_fa = 1'b0;
  logic       temp_sdo = 1'b0;
  logic       temp_cs_n, temp_sclk;
  logic       SFD, SRD, SW, SFA;
  logic [6:0] ST;
  logic       st_valid, st_err;

  int n_checks = 0;
  int n_fail   = 0;
  int valid_cnt = 0;
  int err_cnt   = 0;
  int sclk_rises = 0;
  int tx_idx = 0;
  logic [7:0] tx_bits = 8'h00;

  sensor_frontend dut (
    .clk(clk), .Rst_n(Rst_n),
    .raw_fd(raw_fd), .raw_rd(raw_rd), .raw_w(raw_w), .raw_fa(raw_fa),
    .temp_sdo(temp_sdo), .temp_cs_n(temp_cs_n), .temp_sclk(temp_sclk),
    .SFD(SFD), .SRD(SRD), .SW(SW), .SFA(SFA),
    .ST(ST), .st_valid(st_valid), .st_err(st_err)
  );

  always #5 clk = ~clk;

  always @(negedge temp_cs_n) begin
    tx_idx   = 0;
    temp_sdo = tx_bits[7];
  end

  always @(negedge temp_sclk) begin
    if (!temp_cs_n && tx_idx < 7) begin
      tx_idx   = tx_idx + 1;
      temp_sdo = tx_bits[7 - tx_idx];
    end
  end

  always @(posedge temp_sclk) sclk_rises = sclk_rises + 1;

  always @(negedge clk) begin
    if (st_valid === 1'b1) valid_cnt = valid_cnt + 1;
    if (st_err === 1'b1)   err_cnt   = err_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cs_low(input int limit, output int n);
    n = 0;
    while (temp_cs_n !== 1'b0 && n < limit) begin
      tick(1);
      n++;
    end
  endtask

  task automatic wait_pulse(input logic want_err, input int limit, output int n);
    n = 0;
    while (((want_err ? st_err : st_valid) !== 1'b1) && n < limit) begin
      tick(1);
      n++;
    end
  endtask

  initial begin
    int n;
    logic seen;

    // Reset values
    tick(3);
    check("rst_contacts", 32'({SFD, SRD, SW, SFA}), 32'd0);
    check("rst_st", 32'(ST), 32'd25);
    check("rst_cs_n", 32'(temp_cs_n), 32'd1);
    check("rst_sclk", 32'(temp_sclk), 32'd0);
    check("rst_pulses", 32'({st_valid, st_err}), 32'd0);

    // Good frame: 0x2D with even parity
    tx_bits = {7'h2D, 1'b0};
    Rst_n = 1'b1;
    wait_cs_low(1200, n);
    check("first_trigger", 32'(n), 32'd1000);
    sclk_rises = 0;
    check("select_sclk", 32'(temp_sclk), 32'd0);
    wait_pulse(1'b0, 60, n);
    check("good_latency", 32'(n), 32'd34);
    check("good_st", 32'(ST), 32'd45);
    check("good_sclk_rises", 32'(sclk_rises), 32'd8);
    check("good_cs_n_idle", 32'(temp_cs_n), 32'd1);
    tick(1);
    check("good_valid_pulse", 32'(st_valid), 32'd0);
    check("good_st_hold", 32'(ST), 32'd45);

    // 7-clock glitch on raw_fd must be rejected
    seen = 1'b0;
    raw_fd = 1'b1;
    for (int i = 0; i < 7; i++) begin tick(1); seen |= SFD; end
    raw_fd = 1'b0;
    for (int i = 0; i < 13; i++) begin tick(1); seen |= SFD; end
    check("fd_glitch", 32'(seen), 32'd0);

    // Held rise and fall: exactly 10 clocks
    raw_fd = 1'b1;
    tick(9);
    check("fd_rise_early", 32'(SFD), 32'd0);
    tick(1);
    check("fd_rise", 32'(SFD), 32'd1);
    raw_fd = 1'b0;
    raw_rd = 1'b1;
    tick(9);
    check("fd_fall_early", 32'(SFD), 32'd1);
    tick(1);
    check("fd_fall", 32'(SFD), 32'd0);
    check("rd_rise", 32'({SRD, SW}), 32'd2);
    raw_fd = 1'b1;
    tick(12);

    // 3-clock fire-alarm pulse
    raw_fa = 1'b1;
    tick(1);
    check("fa_t1", 32'(SFA), 32'd0);
    tick(1);
    check("fa_t2", 32'(SFA), 32'(FAST));
    tick(1);
    raw_fa = 1'b0;
    tick(9);
    check("fa_release_early", 32'(SFA), 32'(FAST));
    tick(1);
    check("fa_release", 32'(SFA), 32'd0);

    // Bad parity: ST holds, one st_err
    tx_bits = {7'h2D, 1'b1};
    valid_cnt = 0;
    err_cnt = 0;
    wait_cs_low(1200, n);
    check("bad_trigger_seen", 32'(temp_cs_n), 32'd0);
    wait_pulse(1'b1, 60, n);
    check("bad_latency", 32'(n), 32'd34);
    check("bad_st_hold", 32'(ST), 32'd45);
    tick(1);
    check("bad_err_pulse", 32'(st_err), 32'd0);
    check("bad_counts", 32'({valid_cnt[7:0], err_cnt[7:0]}), 32'h0001);

    // Reset in the middle of bit 4
    tx_bits = {7'h13, 1'b1};
    wait_cs_low(1200, n);
    sclk_rises = 0;
    tick(18);
    check("shift_bits_before_rst", 32'(sclk_rises), 32'd4);
    check("shift_cs_n_low", 32'(temp_cs_n), 32'd0);
    Rst_n = 1'b0;
    valid_cnt = 0;
    err_cnt = 0;
    #1;
    check("mid_rst_cs_n", 32'(temp_cs_n), 32'd1);
    check("mid_rst_sclk", 32'(temp_sclk), 32'd0);
    check("mid_rst_sfd", 32'(SFD), 32'd0);
    check("mid_rst_st", 32'(ST), 32'd25);
    tick(3);
    Rst_n = 1'b1;
    wait_cs_low(1200, n);
    check("rst_retrigger", 32'(n), 32'd1000);
    check("rst_no_pulses", 32'(valid_cnt + err_cnt), 32'd0);
    wait_pulse(1'b0, 60, n);
    check("post_rst_latency", 32'(n), 32'd34);
    check("post_rst_st", 32'(ST), 32'h13);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
